tl_egress_arbiter: RTL and testbench
====================================

# tl_egress_arbiter

Downstream stage of the transaction-layer transfer block: drains the four per-class output FIFOs (P0–P3) into a single 12-bit egress stream toward the link interface. Arbitration is weighted round-robin with a burst limit latched at init. Downstream almost-full backpressure is honoured, and per-port pop counters are readable through the same req/idx counter interface used by the transfer layer.

## Interface
- DATA_WIDTH, 12, width of packet words from P0–P3 and on dataOut
- CNT_WIDTH, 5, width of each pop counter and counterOut
- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- init  input  1  one-cycle pulse; latches burstMax, leaves INIT state
- burstMax  input  3  consecutive pops allowed per port before rotating; 0 is treated as 1
- emptyP0..emptyP3  input  1 each  upstream FIFO empty flags
- dataInP0..dataInP3  input  DATA_WIDTH each  upstream FIFO head word (first-word-fall-through, valid when not empty)
- popP0..popP3  output  1 each  pop strobe to upstream FIFO, at most one high per cycle
- almostFullOut  input  1  downstream almost-full; blocks new pops
- dataOut  output  DATA_WIDTH  registered egress word
- validOut  output  1  dataOut qualifier
- idle  output  1  high in IDLE state
- req  input  1  counter read request
- idx  input  3  counter select: 0–3 port pop count, 4 total, 5–7 reserved
- counterValid  output  1  counterOut qualifier
- counterOut  output  CNT_WIDTH  selected counter value

## Operation
- States: INIT, IDLE, ACTIVE.
- Reset → INIT. In INIT no pops, whatever the FIFO flags.
- INIT → IDLE on init=1. burstMax is latched on that edge.
- IDLE → ACTIVE when any emptyPx=0.
- ACTIVE → IDLE when all emptyPx=1.
- An init pulse in IDLE/ACTIVE re-latches burstMax. The state does not change.
- Pop condition (combinational): state ACTIVE, almostFullOut=0, selected port non-empty.
- Selection: first non-empty port scanning from rrPtr upward, modulo 4.
- burstCnt counts consecutive pops from the current port.
- When burstCnt reaches the latched limit, or the current port shows empty, rrPtr ← selected+1 (mod 4) and burstCnt clears.
- A single non-empty port is re-selected immediately after rotation, so a lone active port runs at full rate.
- Pop counters:
  - Each port counter increments on its pop. The total counter increments on any pop.
  - All counters wrap from 31 to 0.
  - The counters clear only on reset.
- Counter read: req=1 at edge N → counterValid=1 and counterOut=selected value at N+1.
  - The value returned excludes any pop that occurs in cycle N.
  - Reserved idx returns 0 with counterValid=1.

## Timing
- Reset values:
  - popP0..P3=0, dataOut=0, validOut=0, idle=0, counterValid=0, counterOut=0.
  - rrPtr=0, burstCnt=0, latched burstMax=1, all counters 0.
- Pop-to-output latency: 1 cycle. popPx high in cycle N → dataOut=dataInPx (sampled at N), validOut=1 in N+1.
- validOut=0 in any cycle following a cycle without a pop. dataOut holds its last value.
- almostFullOut is sampled in the same cycle as pop. Asserting it in cycle N blocks the pop in N. Words already issued are still delivered.
- Throughput: one word per cycle when not backpressured.
- Reset mid-burst:
  - Outputs take their reset values on the next edge.
  - An in-flight word is dropped and validOut=0.
  - The state returns to INIT.
- idle is registered from the state. It goes high the cycle after entering IDLE.

## Configuration
- EGRESS_STRICT_PRIO_EN defined: fixed priority P0>P1>P2>P3. burstMax and rrPtr are ignored, so a non-empty P0 always wins.
- Undefined (default): weighted round-robin as described above.

## Test plan
- Reset, then init with burstMax=2; P0 and P1 each hold 4 words → pop order P0,P0,P1,P1,P0,P0,P1,P1; dataOut follows one cycle later; the total counter reads 8.
- Only P2 non-empty with 5 words, burstMax=1 → popP2 high on 5 consecutive cycles; idle rises after P2 empties.
- almostFullOut=1 for 3 cycles during a stream → no pops and validOut=0 for those cycles; the stream resumes with no lost or duplicated word.
- 33 pops from P3, then req with idx=3 → counterOut=1 (wrap); idx=6 → counterOut=0 with counterValid=1.
- FIFOs non-empty before init → no pops until init; reset asserted mid-stream → all outputs 0 next cycle and the block is back in INIT.
- With EGRESS_STRICT_PRIO_EN defined, P0 and P3 both non-empty → only P0 pops until it is empty, then P3 pops.

Source files
------------

// File: rtl/tl_egress_arbiter_if.sv
// Egress-side bundle for tl_egress_arbiter: upstream FIFO heads and pops,
// the downstream egress word stream, and the pop-counter read port.
interface tl_egress_arbiter_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 5
);
    logic                  emptyP0, emptyP1, emptyP2, emptyP3;
    logic [DATA_WIDTH-1:0] dataInP0, dataInP1, dataInP2, dataInP3;
    logic                  popP0, popP1, popP2, popP3;
    logic                  almostFullOut;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic                  req;
    logic [2:0]            idx;
    logic                  counterValid;
    logic [CNT_WIDTH-1:0]  counterOut;

    modport master (
        input  emptyP0, emptyP1, emptyP2, emptyP3,
        input  dataInP0, dataInP1, dataInP2, dataInP3,
        input  almostFullOut, req, idx,
        output popP0, popP1, popP2, popP3,
        output dataOut, validOut, counterValid, counterOut
    );

    modport slave (
        output emptyP0, emptyP1, emptyP2, emptyP3,
        output dataInP0, dataInP1, dataInP2, dataInP3,
        output almostFullOut, req, idx,
        input  popP0, popP1, popP2, popP3,
        input  dataOut, validOut, counterValid, counterOut
    );
endinterface

// File: rtl/tl_egress_arbiter.sv
// Drains four per-class FIFOs into one egress stream using weighted round-robin
// with a burst limit; define EGRESS_STRICT_PRIO_EN for fixed priority P0>P1>P2>P3.
module tl_egress_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [2:0]           burstMax,
    output logic                 idle,
    tl_egress_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [2:0]            burst_cnt_q, burst_cnt_d;
    logic [2:0]            burst_lim_q, burst_lim_d;
    logic [CNT_WIDTH-1:0]  port_cnt_q [4];
    logic [CNT_WIDTH-1:0]  port_cnt_d [4];
    logic [CNT_WIDTH-1:0]  total_cnt_q, total_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  idle_q, idle_d;
    logic                  counter_valid_q, counter_valid_d;
    logic [CNT_WIDTH-1:0]  counter_out_q, counter_out_d;

    logic [3:0]            empty_vec;
    logic [DATA_WIDTH-1:0] data_in [4];
    logic [1:0]            cand;
    logic [1:0]            sel_idx;
    logic                  sel_valid;
    logic                  pop;
    logic [2:0]            cnt_base, cnt_next;

    assign empty_vec  = {bus.emptyP3, bus.emptyP2, bus.emptyP1, bus.emptyP0};
    assign data_in[0] = bus.dataInP0;
    assign data_in[1] = bus.dataInP1;
    assign data_in[2] = bus.dataInP2;
    assign data_in[3] = bus.dataInP3;

    // Scan downward so the last hit is the lowest offset, i.e. the first non-empty port.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = rr_ptr_q;
        cand      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
`ifdef EGRESS_STRICT_PRIO_EN
            cand = 2'(i);
`else
            cand = rr_ptr_q + 2'(i);
`endif
            if (!empty_vec[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign pop       = (state_q == ST_ACTIVE) && !bus.almostFullOut && sel_valid;
    assign bus.popP0 = pop && (sel_idx == 2'd0);
    assign bus.popP1 = pop && (sel_idx == 2'd1);
    assign bus.popP2 = pop && (sel_idx == 2'd2);
    assign bus.popP3 = pop && (sel_idx == 2'd3);

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        burst_cnt_d     = burst_cnt_q;
        burst_lim_d     = burst_lim_q;
        port_cnt_d      = port_cnt_q;
        total_cnt_d     = total_cnt_q;
        data_out_d      = data_out_q;
        valid_out_d     = pop;
        idle_d          = (state_q == ST_IDLE);
        counter_valid_d = bus.req;
        counter_out_d   = counter_out_q;

        // A burst only continues if we are still serving the port rrPtr points at.
        cnt_base = (sel_idx == rr_ptr_q) ? burst_cnt_q : 3'd0;
        cnt_next = cnt_base + 3'd1;

        if (init) begin
            burst_lim_d = (burstMax == 3'd0) ? 3'd1 : burstMax;
        end

        case (state_q)
            ST_INIT:   if (init)          state_d = ST_IDLE;
            ST_IDLE:   if (!(&empty_vec)) state_d = ST_ACTIVE;
            ST_ACTIVE: if (&empty_vec)    state_d = ST_IDLE;
            default:                      state_d = ST_INIT;
        endcase

        if (pop) begin
            data_out_d  = data_in[sel_idx];
            total_cnt_d = total_cnt_q + CNT_WIDTH'(1);
            for (int p = 0; p < 4; p++) begin
                if (sel_idx == 2'(p)) begin
                    port_cnt_d[p] = port_cnt_q[p] + CNT_WIDTH'(1);
                end
            end
            if (cnt_next >= burst_lim_q) begin
                rr_ptr_d    = sel_idx + 2'd1;
                burst_cnt_d = 3'd0;
            end else begin
                rr_ptr_d    = sel_idx;
                burst_cnt_d = cnt_next;
            end
        end else if (empty_vec[rr_ptr_q]) begin
            burst_cnt_d = 3'd0;
        end

        if (bus.req) begin
            if (!bus.idx[2]) begin
                counter_out_d = port_cnt_q[bus.idx[1:0]];
            end else if (bus.idx == 3'd4) begin
                counter_out_d = total_cnt_q;
            end else begin
                counter_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            rr_ptr_q        <= 2'd0;
            burst_cnt_q     <= 3'd0;
            burst_lim_q     <= 3'd1;
            port_cnt_q      <= '{default: '0};
            total_cnt_q     <= '0;
            data_out_q      <= '0;
            valid_out_q     <= 1'b0;
            idle_q          <= 1'b0;
            counter_valid_q <= 1'b0;
            counter_out_q   <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            burst_cnt_q     <= burst_cnt_d;
            burst_lim_q     <= burst_lim_d;
            port_cnt_q      <= port_cnt_d;
            total_cnt_q     <= total_cnt_d;
            data_out_q      <= data_out_d;
            valid_out_q     <= valid_out_d;
            idle_q          <= idle_d;
            counter_valid_q <= counter_valid_d;
            counter_out_q   <= counter_out_d;
        end
    end

    assign bus.dataOut      = data_out_q;
    assign bus.validOut     = valid_out_q;
    assign bus.counterValid = counter_valid_q;
    assign bus.counterOut   = counter_out_q;
    assign idle             = idle_q;

endmodule

// File: tb/tb_tl_egress_arbiter.sv
// Directed bench for tl_egress_arbiter: behavioural FIFOs feed the four ports,
// each step's expected pop/egress/counter values are written out by hand.
module tb_tl_egress_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] burstMax;
    logic       idle;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    logic [11:0] q2 [$];
    logic [11:0] q3 [$];

    int exp_port1 [8];
    int exp_data1 [8];
    int exp_port6 [4];
    int exp_data6 [4];

    tl_egress_arbiter_if bus ();

    tl_egress_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .burstMax (burstMax),
        .idle     (idle),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pops_now();
        return {28'd0, bus.popP3, bus.popP2, bus.popP1, bus.popP0};
    endfunction

    task automatic push_word(input int p, input logic [11:0] w);
        case (p)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endtask

    task automatic pop_word(input int p);
        logic [11:0] dummy;
        case (p)
            0: if (q0.size() != 0) dummy = q0.pop_front();
            1: if (q1.size() != 0) dummy = q1.pop_front();
            2: if (q2.size() != 0) dummy = q2.pop_front();
            default: if (q3.size() != 0) dummy = q3.pop_front();
        endcase
    endtask

    task automatic drive_fifos();
        bus.emptyP0  = (q0.size() == 0);
        bus.emptyP1  = (q1.size() == 0);
        bus.emptyP2  = (q2.size() == 0);
        bus.emptyP3  = (q3.size() == 0);
        bus.dataInP0 = (q0.size() != 0) ? q0[0] : 12'd0;
        bus.dataInP1 = (q1.size() != 0) ? q1[0] : 12'd0;
        bus.dataInP2 = (q2.size() != 0) ? q2[0] : 12'd0;
        bus.dataInP3 = (q3.size() != 0) ? q3[0] : 12'd0;
    endtask

    // One clock edge: FIFOs retire whatever the DUT popped just before the edge.
    task automatic applyStimulus();
        int seen;
        #1;
        seen = pops_now();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (seen[p]) pop_word(p);
        end
        drive_fifos();
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
`ifdef EGRESS_STRICT_PRIO_EN
        exp_port1 = '{0, 0, 0, 0, 1, 1, 1, 1};
        exp_data1 = '{'hA00, 'hA01, 'hA02, 'hA03, 'hB00, 'hB01, 'hB02, 'hB03};
        exp_port6 = '{0, 0, 1, 1};
        exp_data6 = '{'hD00, 'hD01, 'hE00, 'hE01};
`else
        exp_port1 = '{0, 0, 1, 1, 0, 0, 1, 1};
        exp_data1 = '{'hA00, 'hA01, 'hB00, 'hB01, 'hA02, 'hA03, 'hB02, 'hB03};
        exp_port6 = '{0, 1, 0, 1};
        exp_data6 = '{'hD00, 'hE00, 'hD01, 'hE01};
`endif
        reset = 1'b1;
        init = 1'b0;
        burstMax = 3'd0;
        bus.almostFullOut = 1'b0;
        bus.req = 1'b0;
        bus.idx = 3'd0;
        for (int k = 0; k < 4; k++) begin
            push_word(0, 12'hA00 + 12'(k));
            push_word(1, 12'hB00 + 12'(k));
        end
        drive_fifos();

        // Reset values, FIFOs already loaded
        applyStimulus();
        applyStimulus();
        checkOutput("rst_pop", pops_now(), 0);
        checkOutput("rst_dataOut", int'(bus.dataOut), 0);
        checkOutput("rst_validOut", int'(bus.validOut), 0);
        checkOutput("rst_idle", int'(idle), 0);
        checkOutput("rst_counterValid", int'(bus.counterValid), 0);
        checkOutput("rst_counterOut", int'(bus.counterOut), 0);

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("init_hold_pop", pops_now(), 0);
            checkOutput("init_hold_idle", int'(idle), 0);
        end

        // WRR with burstMax=2 over P0 and P1
        init = 1'b1;
        burstMax = 3'd2;
        applyStimulus();
        init = 1'b0;
        checkOutput("idle_state_pop", pops_now(), 0);
        checkOutput("idle_not_yet", int'(idle), 0);
        applyStimulus();
        checkOutput("idle_registered", int'(idle), 1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("wrr_pop", pops_now(), 1 << exp_port1[k]);
            applyStimulus();
            checkOutput("wrr_valid", int'(bus.validOut), 1);
            checkOutput("wrr_data", int'(bus.dataOut), exp_data1[k]);
        end
        checkOutput("wrr_drained_pop", pops_now(), 0);
        applyStimulus();
        checkOutput("wrr_valid_low", int'(bus.validOut), 0);
        checkOutput("wrr_data_hold", int'(bus.dataOut), 'hB03);
        applyStimulus();
        checkOutput("wrr_idle_back", int'(idle), 1);

        bus.req = 1'b1;
        bus.idx = 3'd4;
        applyStimulus();
        checkOutput("cnt_total_valid", int'(bus.counterValid), 1);
        checkOutput("cnt_total", int'(bus.counterOut), 8);
        bus.idx = 3'd0;
        applyStimulus();
        checkOutput("cnt_p0", int'(bus.counterOut), 4);
        bus.req = 1'b0;
        applyStimulus();
        checkOutput("cnt_valid_low", int'(bus.counterValid), 0);

        // Lone P2 at full rate with burstMax=1 (re-latched while IDLE)
        init = 1'b1;
        burstMax = 3'd1;
        for (int k = 0; k < 5; k++) push_word(2, 12'h200 + 12'(k));
        drive_fifos();
        applyStimulus();
        init = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("p2_pop", pops_now(), 4);
            applyStimulus();
            checkOutput("p2_data", int'(bus.dataOut), 'h200 + k);
        end
        checkOutput("p2_drained_pop", pops_now(), 0);
        applyStimulus();
        checkOutput("p2_valid_low", int'(bus.validOut), 0);
        checkOutput("p2_idle_low", int'(idle), 0);
        applyStimulus();
        checkOutput("p2_idle_high", int'(idle), 1);

        // Backpressure for 3 cycles mid-stream
        for (int k = 0; k < 6; k++) push_word(0, 12'hC00 + 12'(k));
        drive_fifos();
        applyStimulus();
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                bus.almostFullOut = 1'b1;
                #1;
                for (int b = 0; b < 3; b++) begin
                    checkOutput("bp_pop", pops_now(), 0);
                    applyStimulus();
                    checkOutput("bp_valid", int'(bus.validOut), 0);
                    checkOutput("bp_data_hold", int'(bus.dataOut), 'hC01);
                end
                bus.almostFullOut = 1'b0;
                #1;
            end
            checkOutput("bp_stream_pop", pops_now(), 1);
            applyStimulus();
            checkOutput("bp_stream_data", int'(bus.dataOut), 'hC00 + k);
        end
        applyStimulus();
        applyStimulus();

        // Reset in the middle of a P1 stream
        for (int k = 0; k < 4; k++) push_word(1, 12'h100 + 12'(k));
        drive_fifos();
        applyStimulus();
        checkOutput("mid_pop", pops_now(), 2);
        applyStimulus();
        checkOutput("mid_data", int'(bus.dataOut), 'h100);
        reset = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_pop", pops_now(), 0);
        checkOutput("mid_rst_valid", int'(bus.validOut), 0);
        checkOutput("mid_rst_data", int'(bus.dataOut), 0);
        checkOutput("mid_rst_idle", int'(idle), 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("mid_rst_init_pop", pops_now(), 0);
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        drive_fifos();
        bus.req = 1'b1;
        bus.idx = 3'd4;
        applyStimulus();
        checkOutput("mid_rst_total", int'(bus.counterOut), 0);
        bus.req = 1'b0;

        // 33 pops from P3: counter wrap and pre-pop read value
        init = 1'b1;
        burstMax = 3'd3;
        for (int k = 0; k < 33; k++) push_word(3, 12'h300 + 12'(k));
        drive_fifos();
        applyStimulus();
        init = 1'b0;
        applyStimulus();
        for (int k = 0; k < 33; k++) begin
            if (k == 5) begin
                bus.req = 1'b1;
                bus.idx = 3'd3;
            end
            checkOutput("p3_pop", pops_now(), 8);
            applyStimulus();
            checkOutput("p3_data", int'(bus.dataOut), 'h300 + k);
            if (k == 5) begin
                bus.req = 1'b0;
                checkOutput("p3_read_valid", int'(bus.counterValid), 1);
                checkOutput("p3_read_prepop", int'(bus.counterOut), 5);
            end
        end
        checkOutput("p3_drained_pop", pops_now(), 0);
        applyStimulus();
        bus.req = 1'b1;
        bus.idx = 3'd3;
        applyStimulus();
        checkOutput("wrap_p3_valid", int'(bus.counterValid), 1);
        checkOutput("wrap_p3", int'(bus.counterOut), 1);
        bus.idx = 3'd6;
        applyStimulus();
        checkOutput("reserved_valid", int'(bus.counterValid), 1);
        checkOutput("reserved_zero", int'(bus.counterOut), 0);
        bus.idx = 3'd4;
        applyStimulus();
        checkOutput("wrap_total", int'(bus.counterOut), 1);
        bus.req = 1'b0;
        applyStimulus();

        // burstMax=0 behaves as 1
        init = 1'b1;
        burstMax = 3'd0;
        push_word(0, 12'hD00);
        push_word(0, 12'hD01);
        push_word(1, 12'hE00);
        push_word(1, 12'hE01);
        drive_fifos();
        applyStimulus();
        init = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bmax0_pop", pops_now(), 1 << exp_port6[k]);
            applyStimulus();
            checkOutput("bmax0_data", int'(bus.dataOut), exp_data6[k]);
        end
        checkOutput("bmax0_drained_pop", pops_now(), 0);
        applyStimulus();

`ifdef EGRESS_STRICT_PRIO_EN
        // P0 keeps winning over P3 until it is empty
        for (int k = 0; k < 3; k++) push_word(0, 12'hF00 + 12'(k));
        push_word(3, 12'hF30);
        push_word(3, 12'hF31);
        drive_fifos();
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            checkOutput("strict_pop", pops_now(), (k < 3) ? 1 : 8);
            applyStimulus();
            checkOutput("strict_data", int'(bus.dataOut), (k < 3) ? ('hF00 + k) : ('hF30 + k - 3));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
